// File: rtl/alu_issue_queue.sv
// Issue stage for my_alu: buffers commands in a FIFO, issues one at a time, waits ALU latency, holds result.
// Optional ALU_ISSUE_STATS_EN adds issue_count/ovf_count statistics outputs.
module alu_issue_queue #(
    parameter int NUMBITS     = 16,
    parameter int DEPTH       = 4,
    parameter int ALU_LATENCY = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [NUMBITS-1:0] in_a,
    input  logic [NUMBITS-1:0] in_b,
    input  logic [2:0]         in_opcode,
    output logic [NUMBITS-1:0] alu_a,
    output logic [NUMBITS-1:0] alu_b,
    output logic [2:0]         alu_opcode,
    input  logic [NUMBITS-1:0] alu_result,
    input  logic               alu_carryout,
    input  logic               alu_overflow,
    input  logic               alu_zero,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NUMBITS-1:0] out_result,
    output logic [2:0]         out_opcode,
    output logic               out_carryout,
    output logic               out_overflow,
    output logic               out_zero,
`ifdef ALU_ISSUE_STATS_EN
    output logic [15:0]        issue_count,
    output logic [15:0]        ovf_count,
`endif
    output logic               busy
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WAIT_W = $clog2(ALU_LATENCY + 1);
    localparam int ENTRY_W = 2 * NUMBITS + 3;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    state_t               r_state, w_nextState;
    logic [ENTRY_W-1:0]   r_mem [DEPTH];
    logic [PTR_W-1:0]     r_wrPtr, r_rdPtr;
    logic [CNT_W-1:0]     r_count;
    logic [WAIT_W-1:0]    r_waitCnt;
    logic [NUMBITS-1:0]   r_aluA, r_aluB, r_outResult;
    logic [2:0]           r_aluOpcode, r_outOpcode;
    logic                 r_outValid, r_outCarry, r_outOverflow, r_outZero;
    logic                 w_push, w_pop, w_capture, w_outFire, w_notEmpty;
    logic [ENTRY_W-1:0]   w_head;

    // Ready depends only on registered count, so a same-cycle pop never opens a full FIFO.
    assign in_ready   = (r_count != CNT_W'(DEPTH));
    assign w_notEmpty = (r_count != '0);
    assign w_push     = in_valid && in_ready;
    assign w_pop      = (r_state == ISSUE);
    assign w_capture  = (r_state == WAIT) && (r_waitCnt == WAIT_W'(1));
    assign w_outFire  = r_outValid && out_ready;
    assign w_head     = r_mem[r_rdPtr];

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:  if (w_notEmpty) w_nextState = ISSUE;
            ISSUE: w_nextState = WAIT;
            WAIT:  if (w_capture) w_nextState = HOLD;
            HOLD:  if (w_outFire) w_nextState = w_notEmpty ? ISSUE : IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wrPtr] <= {in_opcode, in_b, in_a};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wrPtr <= r_wrPtr + PTR_W'(1);
            if (w_pop)  r_rdPtr <= r_rdPtr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Issue registers and latency counter; operands stay put until the next issue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_aluA      <= '0;
            r_aluB      <= '0;
            r_aluOpcode <= '0;
            r_waitCnt   <= '0;
        end else if (r_state == ISSUE) begin
            r_aluA      <= w_head[NUMBITS-1:0];
            r_aluB      <= w_head[2*NUMBITS-1:NUMBITS];
            r_aluOpcode <= w_head[ENTRY_W-1:2*NUMBITS];
            r_waitCnt   <= WAIT_W'(ALU_LATENCY);
        end else if (r_state == WAIT) begin
            r_waitCnt   <= r_waitCnt - WAIT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_outValid    <= 1'b0;
            r_outResult   <= '0;
            r_outOpcode   <= '0;
            r_outCarry    <= 1'b0;
            r_outOverflow <= 1'b0;
            r_outZero     <= 1'b0;
        end else if (w_capture) begin
            r_outValid    <= 1'b1;
            r_outResult   <= alu_result;
            r_outOpcode   <= r_aluOpcode;
            r_outCarry    <= alu_carryout;
            r_outOverflow <= alu_overflow;
            r_outZero     <= alu_zero;
        end else if (w_outFire) begin
            r_outValid    <= 1'b0;
        end
    end

`ifdef ALU_ISSUE_STATS_EN
    logic [15:0] r_issueCount, r_ovfCount;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_issueCount <= '0;
            r_ovfCount   <= '0;
        end else begin
            if (r_state == ISSUE)           r_issueCount <= r_issueCount + 16'd1;
            if (w_capture && alu_overflow)  r_ovfCount   <= r_ovfCount + 16'd1;
        end
    end

    assign issue_count = r_issueCount;
    assign ovf_count   = r_ovfCount;
`endif

    assign alu_a        = r_aluA;
    assign alu_b        = r_aluB;
    assign alu_opcode   = r_aluOpcode;
    assign out_valid    = r_outValid;
    assign out_result   = r_outResult;
    assign out_opcode   = r_outOpcode;
    assign out_carryout = r_outCarry;
    assign out_overflow = r_outOverflow;
    assign out_zero     = r_outZero;
    assign busy         = (r_state != IDLE) || w_notEmpty;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Self-checking bench for alu_issue_queue: behavioural ALU model feeds the DUT, results checked via a scoreboard.
// A second instance with ALU_LATENCY=3 checks the longer-latency timing.
module tb_alu_issue_queue;

    typedef struct packed {
        logic [15:0] result;
        logic [2:0]  opcode;
        logic        c;
        logic        o;
        logic        z;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0, in_ready;
    logic [15:0] in_a = '0, in_b = '0;
    logic [2:0]  in_opcode = '0;
    logic [15:0] alu_a, alu_b, alu_result;
    logic [2:0]  alu_opcode;
    logic        alu_carryout, alu_overflow, alu_zero;
    logic        out_valid, out_ready = 1'b0;
    logic [15:0] out_result;
    logic [2:0]  out_opcode;
    logic        out_carryout, out_overflow, out_zero, busy;
`ifdef ALU_ISSUE_STATS_EN
    logic [15:0] issue_count, ovf_count;
`endif

    logic        in_valid3 = 1'b0, in_ready3;
    logic [15:0] in_a3 = '0, in_b3 = '0;
    logic [2:0]  in_opcode3 = '0;
    logic [15:0] alu_a3, alu_b3, alu_result3;
    logic [2:0]  alu_opcode3;
    logic        alu_carryout3, alu_overflow3, alu_zero3;
    logic        out_valid3, out_ready3 = 1'b1;
    logic [15:0] out_result3;
    logic [2:0]  out_opcode3;
    logic        out_carryout3, out_overflow3, out_zero3, busy3;
`ifdef ALU_ISSUE_STATS_EN
    logic [15:0] issue_count3, ovf_count3;
`endif

    int   compared = 0;
    int   mismatched = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    function automatic exp_t aluModel(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
        exp_t        e;
        logic [16:0] s;
        e.opcode = op;
        case (op)
            3'b000: begin
                s = {1'b0, a} + {1'b0, b};
                e.result = s[15:0];
                e.c = s[16];
                e.o = (a[15] == b[15]) && (s[15] != a[15]);
            end
            3'b001: begin
                s = {1'b0, a} - {1'b0, b};
                e.result = s[15:0];
                e.c = s[16];
                e.o = (a[15] != b[15]) && (s[15] != a[15]);
            end
            default: begin
                e.result = a ^ b;
                e.c = 1'b0;
                e.o = 1'b0;
            end
        endcase
        e.z = (e.result == 16'h0000);
        return e;
    endfunction

    // Behavioural ALU driven from the registered operands of each instance.
    always_comb begin
        exp_t m;
        m = aluModel(alu_a, alu_b, alu_opcode);
        alu_result   = m.result;
        alu_carryout = m.c;
        alu_overflow = m.o;
        alu_zero     = m.z;
    end

    always_comb begin
        exp_t m3;
        m3 = aluModel(alu_a3, alu_b3, alu_opcode3);
        alu_result3   = m3.result;
        alu_carryout3 = m3.c;
        alu_overflow3 = m3.o;
        alu_zero3     = m3.z;
    end

    alu_issue_queue #(.NUMBITS(16), .DEPTH(4), .ALU_LATENCY(1)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_opcode(in_opcode),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_result(alu_result), .alu_carryout(alu_carryout),
        .alu_overflow(alu_overflow), .alu_zero(alu_zero),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_opcode(out_opcode),
        .out_carryout(out_carryout), .out_overflow(out_overflow), .out_zero(out_zero),
`ifdef ALU_ISSUE_STATS_EN
        .issue_count(issue_count), .ovf_count(ovf_count),
`endif
        .busy(busy)
    );

    alu_issue_queue #(.NUMBITS(16), .DEPTH(4), .ALU_LATENCY(3)) dut3 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid3), .in_ready(in_ready3),
        .in_a(in_a3), .in_b(in_b3), .in_opcode(in_opcode3),
        .alu_a(alu_a3), .alu_b(alu_b3), .alu_opcode(alu_opcode3),
        .alu_result(alu_result3), .alu_carryout(alu_carryout3),
        .alu_overflow(alu_overflow3), .alu_zero(alu_zero3),
        .out_valid(out_valid3), .out_ready(out_ready3),
        .out_result(out_result3), .out_opcode(out_opcode3),
        .out_carryout(out_carryout3), .out_overflow(out_overflow3), .out_zero(out_zero3),
`ifdef ALU_ISSUE_STATS_EN
        .issue_count(issue_count3), .ovf_count(ovf_count3),
`endif
        .busy(busy3)
    );

    // Every accepted result is compared in order against the scoreboard.
    always @(negedge clk) begin
        exp_t got, want;
        if (!reset && out_valid && out_ready) begin
            got = '{result: out_result, opcode: out_opcode, c: out_carryout, o: out_overflow, z: out_zero};
            compared++;
            if (sb.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL unexpected_result: got %h, none expected", got);
            end else begin
                want = sb.pop_front();
                if (got !== want) begin
                    mismatched++;
                    $display("[TB] FAIL result_order: got %h expected %h", got, want);
                end
            end
        end
    end

    task automatic pushCmd(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_opcode = op;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                sb.push_back(aluModel(a, b, op));
                done = 1'b1;
            end else begin
                n++;
                if (n > 200) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL push_timeout: in_ready %b expected 1", in_ready);
                    done = 1'b1;
                end else begin
                    @(posedge clk);
                end
            end
        end
        #1 in_valid = 1'b0;
    endtask

    task automatic waitIdle(input string name);
        int n;
        n = 0;
        while ((busy || out_valid || sb.size() != 0) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 300) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s_drain_timeout: busy %b pending %0d expected idle", name, busy, sb.size());
        end
    endtask

    task automatic test_reset;
        #1;
        compared++;
        if ({out_valid, busy, out_result, out_opcode, out_carryout, out_overflow, out_zero} !== '0) begin
            mismatched++;
            $display("[TB] FAIL reset_outputs: got %b/%b/%h/%h/%b%b%b expected zeros",
                     out_valid, busy, out_result, out_opcode, out_carryout, out_overflow, out_zero);
        end
        compared++;
        if ({alu_a, alu_b, alu_opcode} !== '0) begin
            mismatched++;
            $display("[TB] FAIL reset_alu_regs: got %h %h %h expected 0", alu_a, alu_b, alu_opcode);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        compared++;
        if (in_ready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_single_op;
        out_ready = 1'b1;
        pushCmd(16'h0005, 16'h0003, 3'b000);
        @(posedge clk);
        #1;
        compared++;
        if (out_valid !== 1'b0 || alu_a !== 16'h0000) begin
            mismatched++;
            $display("[TB] FAIL single_cycle1: out_valid %b alu_a %h expected 0 0000", out_valid, alu_a);
        end
        @(posedge clk);
        #1;
        compared++;
        if (alu_a !== 16'h0005 || alu_b !== 16'h0003 || out_valid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL single_cycle2: alu_a %h alu_b %h out_valid %b expected 0005 0003 0", alu_a, alu_b, out_valid);
        end
        @(posedge clk);
        #1;
        compared++;
        if (out_valid !== 1'b1 || out_result !== 16'h0008 || out_opcode !== 3'b000) begin
            mismatched++;
            $display("[TB] FAIL single_cycle3: out_valid %b result %h opcode %h expected 1 0008 0", out_valid, out_result, out_opcode);
        end
        waitIdle("single");
    endtask

    task automatic test_fill_backpressure;
        int n;
        bit stalledOk;
        out_ready = 1'b0;
        pushCmd(16'h1111, 16'h0001, 3'b000);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        compared++;
        if (out_valid !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL fill_hold: out_valid %b expected 1", out_valid);
        end
        for (int i = 2; i <= 5; i++) begin
            pushCmd(16'h1000 * i[15:0] + 16'h0033, 16'h0101 * i[15:0], 3'(i % 3));
        end
        compared++;
        if (in_ready !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL fill_in_ready: got %b expected 0", in_ready);
        end
        in_valid = 1'b1;
        in_a = 16'hBEEF;
        in_b = 16'h1234;
        in_opcode = 3'b001;
        stalledOk = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || busy !== 1'b1) stalledOk = 1'b0;
        end
        compared++;
        if (!stalledOk) begin
            mismatched++;
            $display("[TB] FAIL fill_stall: in_ready %b out_valid %b busy %b expected 0 1 1", in_ready, out_valid, busy);
        end
        out_ready = 1'b1;
        pushCmd(16'hBEEF, 16'h1234, 3'b001);
        waitIdle("fill");
    endtask

    task automatic test_flags;
        int n;
        logic [18:0] snap;
        out_ready = 1'b0;
        pushCmd(16'h8000, 16'h8000, 3'b000);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        compared++;
        if ({out_valid, out_carryout, out_overflow, out_zero} !== 4'b1111 || out_result !== 16'h0000) begin
            mismatched++;
            $display("[TB] FAIL flags_capture: valid/c/o/z %b%b%b%b result %h expected 1111 0000",
                     out_valid, out_carryout, out_overflow, out_zero, out_result);
        end
        snap = {out_result, out_carryout, out_overflow, out_zero};
        repeat (4) @(posedge clk);
        #1;
        compared++;
        if ({out_result, out_carryout, out_overflow, out_zero} !== snap || out_valid !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL flags_stable: got %h valid %b expected %h valid 1",
                     {out_result, out_carryout, out_overflow, out_zero}, out_valid, snap);
        end
        out_ready = 1'b1;
        waitIdle("flags");
    endtask

    task automatic test_reset_mid_wait;
        bit quiet;
        out_ready = 1'b0;
        pushCmd(16'h0A0A, 16'h0101, 3'b000);
        pushCmd(16'h0B0B, 16'h0202, 3'b001);
        pushCmd(16'h0C0C, 16'h0303, 3'b010);
        reset = 1'b1;
        #1;
        compared++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL reset_mid_wait: out_valid %b busy %b in_ready %b expected 0 0 1", out_valid, busy, in_ready);
        end
        sb.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        out_ready = 1'b1;
        quiet = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
        end
        compared++;
        if (!quiet) begin
            mismatched++;
            $display("[TB] FAIL reset_no_result: out_valid %b busy %b expected 0 0", out_valid, busy);
        end
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            pushCmd(16'h7000 + 16'(i * 77), 16'h0100 + 16'(i * 3), 3'(i % 4));
        end
        waitIdle("b2b");
    endtask

    task automatic test_latency3;
        exp_t want;
        logic early;
        want = aluModel(16'h1234, 16'h4321, 3'b001);
        early = 1'b0;
        in_a3 = 16'h1234;
        in_b3 = 16'h4321;
        in_opcode3 = 3'b001;
        in_valid3 = 1'b1;
        @(posedge clk);
        #1 in_valid3 = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            if (out_valid3 !== 1'b0) early = 1'b1;
        end
        compared++;
        if (early) begin
            mismatched++;
            $display("[TB] FAIL lat3_early: out_valid3 high before cycle 5, expected 0");
        end
        @(posedge clk);
        #1;
        compared++;
        if (out_valid3 !== 1'b1 || out_result3 !== want.result || out_carryout3 !== want.c || out_overflow3 !== want.o) begin
            mismatched++;
            $display("[TB] FAIL lat3_capture: valid %b result %h c %b o %b expected 1 %h %b %b",
                     out_valid3, out_result3, out_carryout3, out_overflow3, want.result, want.c, want.o);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

`ifdef ALU_ISSUE_STATS_EN
    task automatic test_stats;
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        out_ready = 1'b1;
        pushCmd(16'h0001, 16'h0001, 3'b000);
        pushCmd(16'h7FFF, 16'h0001, 3'b000);
        pushCmd(16'h0002, 16'h0002, 3'b000);
        waitIdle("stats");
        compared++;
        if (issue_count !== 16'd3 || ovf_count !== 16'd1) begin
            mismatched++;
            $display("[TB] FAIL stats_counts: issue %0d ovf %0d expected 3 1", issue_count, ovf_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_op();
        test_fill_backpressure();
        test_flags();
        test_back_to_back();
        test_reset_mid_wait();
        test_latency3();
`ifdef ALU_ISSUE_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/alu_issue_queue.md
# alu_issue_queue

Upstream issue stage for `my_alu`. It accepts operation commands (A, B, opcode) over a valid/ready handshake and buffers them in a small FIFO. It issues one command at a time to the ALU's operand inputs, waits the ALU's fixed latency, then captures result and flags into an output register held under valid/ready backpressure. It decouples command producers from the ALU's registered timing.

## Interface
- `NUMBITS`, 16, operand/result width; matches ALU `NUMBITS`
- `DEPTH`, 4, command FIFO entries; power of two, ≥2
- `ALU_LATENCY`, 1, cycles from operands registered at the ALU inputs to the ALU result being valid; ≥1

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  command present
- `in_ready`  out  1  FIFO can accept a command
- `in_a`, `in_b`  in  NUMBITS  command operands
- `in_opcode`  in  3  command opcode, passed through unmodified
- `alu_a`, `alu_b`  out  NUMBITS  registered operands to ALU `A`/`B`
- `alu_opcode`  out  3  registered opcode to ALU `opcode`
- `alu_result`  in  NUMBITS  from ALU `result`
- `alu_carryout`, `alu_overflow`, `alu_zero`  in  1  from ALU flags
- `out_valid`  out  1  captured result available
- `out_ready`  in  1  consumer accepts result
- `out_result`  out  NUMBITS  captured result
- `out_opcode`  out  3  opcode of the captured operation
- `out_carryout`, `out_overflow`, `out_zero`  out  1  captured flags
- `busy`  out  1  high when FSM ≠ IDLE or FIFO non-empty

## Operation
- FIFO: `in_ready = !full`; push on `in_valid && in_ready`. Pop only in ISSUE. Push and pop in the same cycle are both honoured, and the count is unchanged.
- When full, `in_ready` is low even if a pop occurs in that cycle; no combinational ready-through.
- Pointers wrap modulo `DEPTH`. Count width is log2(DEPTH)+1.
- FSM states: IDLE, ISSUE, WAIT, HOLD.
  - IDLE: FIFO non-empty → ISSUE.
  - ISSUE (1 cycle): pop the head. `alu_a`, `alu_b` and `alu_opcode` load on the closing edge. Load the wait counter with `ALU_LATENCY`. → WAIT.
  - WAIT: decrement the counter each cycle. On the edge where the counter reaches 0, capture `alu_*` and the issued opcode into the `out_*` registers and set `out_valid`. → HOLD.
  - HOLD: `out_valid=1`, outputs stable. On `out_valid && out_ready`, clear `out_valid`. Then → ISSUE if the FIFO is non-empty, else → IDLE.
- `alu_a`, `alu_b` and `alu_opcode` hold their last issued values outside ISSUE.
- No arithmetic is performed; all widths pass through unchanged.

## Timing
- Reset (async, immediate), all of the following go to 0 or empty:
  - FIFO empty, pointers 0
  - FSM = IDLE
  - `in_ready=1` (after reset deasserts)
  - `alu_a=alu_b=0`, `alu_opcode=0`
  - `out_valid=0`, `out_result=0`, `out_opcode=0`, all `out_*` flags 0
  - `busy=0`
- Reset mid-operation drops the in-flight command and all queued commands; no result is produced for them.
- Latency: a push on edge t0 into an empty, idle block gives ISSUE in cycle t0+1 and `out_valid` high from cycle t0+2+`ALU_LATENCY`.
- Throughput: one result per `ALU_LATENCY`+2 cycles when `out_ready` is held high.
- With `out_ready` low, HOLD persists indefinitely. The FIFO keeps accepting commands until full.

## Configuration
- Macro: `ALU_ISSUE_STATS_EN`.
- Defined:
  - Adds output `issue_count` (16 bits), incremented on each ISSUE cycle.
  - Adds output `ovf_count` (16 bits), incremented on each capture with `alu_overflow=1`.
  - Both counters wrap at 16'hFFFF→0 and reset to 0.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

## Test plan
- Single op: after reset, push A=16'h0005, B=16'h0003, opcode=3'b000. The bench ALU model returns 16'h0008, flags 0 at latency 1. Expect `alu_a=5` in cycle 2, `out_valid` in cycle 3 with `out_result=16'h0008`, `out_opcode=0`.
- Fill/backpressure: hold `out_ready=0` and push 6 commands. Expect 1 in HOLD and 4 in the FIFO, `in_ready=0` after the 5th accepted command, and the 6th stalled. Release `out_ready`: 6 results delivered in push order.
- Flag capture: the model returns result 0, `alu_zero=1`, `alu_overflow=1`, `alu_carryout=1` for A=16'h8000, B=16'h8000. Expect all three `out_*` flags set, held stable while `out_ready=0`.
- Reset mid-WAIT: assert `reset` during WAIT with 2 commands queued. Expect `out_valid=0`, `busy=0`, `in_ready=1` immediately, and no result after reset release.
- `ALU_LATENCY=3`: a push into an idle block gives `out_valid` exactly 5 cycles after the push edge, and the captured value is the model's output at that edge.
- With `ALU_ISSUE_STATS_EN`: 3 ops, one overflowing → `issue_count=3`, `ovf_count=1`.
